// File: rtl/mole_round_ctrl_pkg.sv
// Shared types and constants for the whack-a-mole round controller.
// Holds the FSM state encoding, guess codes and the hole-pick helper.
package mole_round_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_GAP  = 2'd0,
        ST_SHOW = 2'd1,
        ST_OVER = 2'd2
    } state_t;

    localparam int unsigned NUM_HOLES = 5;
    localparam int unsigned LFSR_W    = 16;
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

    localparam logic [2:0] GUESS_UP     = 3'd0;
    localparam logic [2:0] GUESS_LEFT   = 3'd1;
    localparam logic [2:0] GUESS_CENTER = 3'd2;
    localparam logic [2:0] GUESS_RIGHT  = 3'd3;
    localparam logic [2:0] GUESS_DOWN   = 3'd4;
    localparam logic [2:0] GUESS_NONE   = 3'd5;
    localparam logic [2:0] NO_MOLE      = 3'd5;

    // Fold a 3-bit random value onto the five holes.
    function automatic logic [2:0] pick(input logic [2:0] p);
        if (p >= 3'(NUM_HOLES)) begin
            return p - 3'(NUM_HOLES);
        end
        return p;
    endfunction

endpackage

// File: rtl/mole_round_ctrl_lfsr.sv
// Free-running 16-bit Galois LFSR; only the low three bits leave the block
// because that is all the hole picker consumes.
module mole_lfsr
    import mole_round_ctrl_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
    input  logic       clk,
    input  logic       rst,
    output logic [2:0] low_bits
);

    logic [LFSR_W-1:0] state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= SEED;
        end else begin
            state <= {1'b0, state[LFSR_W-1:1]} ^ (state[0] ? LFSR_TAPS : '0);
        end
    end

    assign low_bits = state[2:0];

endmodule

// File: rtl/mole_round_ctrl.sv
// Whack-a-mole round controller: gap, response window with scoring, timeout
// and miss counting, and a terminal game-over state held until reset.
module mole_round_ctrl
    import mole_round_ctrl_pkg::*;
#(
    parameter int unsigned GAP_TICKS   = 25_000_000,
    parameter int unsigned ROUND_TICKS = 100_000_000,
    parameter int unsigned MAX_MISSES  = 3,
    parameter int unsigned SCORE_W     = 8,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               eval_now,
    input  logic [2:0]         user_guess,
    output logic               guess_now,
    output logic [2:0]         mole_pos,
    output logic [SCORE_W-1:0] score,
    output logic [1:0]         misses,
    output logic               hit_pulse,
    output logic               miss_pulse,
    output logic               game_over
);

    localparam int unsigned MAX_TICKS = (GAP_TICKS > ROUND_TICKS) ? GAP_TICKS : ROUND_TICKS;
    localparam int unsigned CNT_W     = (MAX_TICKS > 2) ? $clog2(MAX_TICKS) : 1;
    localparam logic [CNT_W-1:0]   GAP_LAST   = CNT_W'(GAP_TICKS - 1);
    localparam logic [CNT_W-1:0]   ROUND_LAST = CNT_W'(ROUND_TICKS - 1);
    localparam logic [SCORE_W-1:0] SCORE_MAX  = {SCORE_W{1'b1}};
    localparam logic [1:0]         MISS_LIMIT = 2'(MAX_MISSES);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       lfsr_bits;
    logic             answer;
    logic             timeout;
    logic [1:0]       misses_next;

    mole_lfsr #(
        .SEED(LFSR_SEED)
    ) u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .low_bits(lfsr_bits)
    );

    // First window cycle is blind: eval_now may still be held from the last round.
    assign answer      = eval_now && (cnt != '0) && (user_guess < GUESS_NONE);
    assign timeout     = (cnt == ROUND_LAST);
    assign misses_next = misses + 2'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_GAP;
            cnt        <= '0;
            guess_now  <= 1'b0;
            mole_pos   <= NO_MOLE;
            score      <= '0;
            misses     <= '0;
            hit_pulse  <= 1'b0;
            miss_pulse <= 1'b0;
            game_over  <= 1'b0;
        end else begin
            hit_pulse  <= 1'b0;
            miss_pulse <= 1'b0;
            case (state)
                ST_GAP: begin
                    if (cnt == GAP_LAST) begin
                        cnt       <= '0;
                        mole_pos  <= pick(lfsr_bits);
                        guess_now <= 1'b1;
                        state     <= ST_SHOW;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_SHOW: begin
                    // An answer arriving on the timeout cycle still counts as an answer.
                    if (answer || timeout) begin
                        cnt       <= '0;
                        guess_now <= 1'b0;
                        mole_pos  <= NO_MOLE;
                        if (answer && (user_guess == mole_pos)) begin
                            hit_pulse <= 1'b1;
                            if (score != SCORE_MAX) begin
                                score <= score + SCORE_W'(1);
                            end
                            state <= ST_GAP;
                        end else begin
                            miss_pulse <= 1'b1;
                            misses     <= misses_next;
                            if (misses_next == MISS_LIMIT) begin
                                game_over <= 1'b1;
                                state     <= ST_OVER;
                            end else begin
                                state <= ST_GAP;
                            end
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_OVER: begin
                    game_over <= 1'b1;
                end
                default: begin
                    state <= ST_GAP;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mole_round_ctrl.sv
// Randomized scoreboard bench for mole_round_ctrl with short gap/window timing.
// A driver plays rounds and queues expected outcomes; a monitor checks each pulse.
module tb_mole_round_ctrl;

    localparam int GAP   = 4;
    localparam int ROUND = 8;
    localparam int MAXM  = 3;
    localparam int SW    = 2;
    localparam int SMAX  = (1 << SW) - 1;
    localparam logic [15:0] SEED = 16'hACE1;

    localparam int K_HIT     = 0;
    localparam int K_WRONG   = 1;
    localparam int K_TIMEOUT = 2;
    localparam int K_NONE    = 3;
    localparam int K_STALE   = 4;
    localparam int K_RESET   = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          eval_now;
    logic [2:0]    user_guess;
    logic          guess_now;
    logic [2:0]    mole_pos;
    logic [SW-1:0] score;
    logic [1:0]    misses;
    logic          hit_pulse;
    logic          miss_pulse;
    logic          game_over;

    mole_round_ctrl #(
        .GAP_TICKS  (GAP),
        .ROUND_TICKS(ROUND),
        .MAX_MISSES (MAXM),
        .SCORE_W    (SW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .eval_now  (eval_now),
        .user_guess(user_guess),
        .guess_now (guess_now),
        .mole_pos  (mole_pos),
        .score     (score),
        .misses    (misses),
        .hit_pulse (hit_pulse),
        .miss_pulse(miss_pulse),
        .game_over (game_over)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit hit;
        int score;
        int misses;
        bit over;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_err    = 0;
    int   exp_score;
    int   exp_misses;
    int   first_mole = -1;
    bit   after_reset;

    // Reference random source: the documented Galois LFSR, tracked per clock.
    logic [15:0] m_lfsr;
    logic [15:0] m_prev;

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        if (v[0]) return (v >> 1) ^ 16'hB400;
        return v >> 1;
    endfunction

    function automatic int hole_of(input logic [15:0] v);
        int p;
        p = int'(v[2:0]);
        return p % 5;
    endfunction

    always @(posedge clk) begin
        m_prev <= m_lfsr;
        m_lfsr <= rst ? SEED : lfsr_step(m_lfsr);
    end

    function automatic exp_t make_exp(input bit hit, input int s, input int m);
        exp_t e;
        e.hit    = hit;
        e.score  = s;
        e.misses = m;
        e.over   = (m == MAXM);
        return e;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic finish_run();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    endtask

    // Monitor: every outcome pulse must match the next queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && (hit_pulse || miss_pulse)) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL unexpected_pulse: hit=%0b miss=%0b with nothing expected at %0t",
                         hit_pulse, miss_pulse, $time);
            end else begin
                e = sb.pop_front();
                check("hit_pulse", int'(hit_pulse), int'(e.hit));
                check("miss_pulse", int'(miss_pulse), int'(!e.hit));
                check("score", int'(score), e.score);
                check("misses", int'(misses), e.misses);
                check("game_over", int'(game_over), int'(e.over));
                check("guess_now_closed", int'(guess_now), 0);
                check("mole_cleared", int'(mole_pos), 5);
            end
        end
    end

    task automatic do_reset();
        rst        = 1'b1;
        eval_now   = 1'b0;
        user_guess = 3'd5;
        @(negedge clk);
        check("rst_guess_now", int'(guess_now), 0);
        check("rst_mole_pos", int'(mole_pos), 5);
        check("rst_score", int'(score), 0);
        check("rst_misses", int'(misses), 0);
        check("rst_hit_pulse", int'(hit_pulse), 0);
        check("rst_miss_pulse", int'(miss_pulse), 0);
        check("rst_game_over", int'(game_over), 0);
        check("rst_sb_empty", sb.size(), 0);
        sb.delete();
        rst         = 1'b0;
        exp_score   = 0;
        exp_misses  = 0;
        after_reset = 1'b1;
    endtask

    task automatic wait_show(output int gap, output bit ok);
        gap = 0;
        while (guess_now !== 1'b1 && gap < 64) begin
            gap++;
            @(negedge clk);
        end
        ok = (guess_now === 1'b1);
    endtask

    // Play one round; ans_j is the window cycle of the answer (or of the reset).
    task automatic play_round(input int kind, input int ans_j, input int off);
        int gap;
        bit ok;
        int mole;
        int g;
        bit answered;
        answered = 1'b0;
        if (kind == K_STALE) begin
            eval_now   = 1'b1;
            user_guess = 3'($urandom_range(0, 4));
        end
        wait_show(gap, ok);
        if (!ok) begin
            n_checks++;
            n_err++;
            $display("FAIL show_wait: window never opened after %0d cycles", gap);
            finish_run();
        end
        check("gap_len", gap, GAP);
        mole = hole_of(m_prev);
        check("mole_at_show", int'(mole_pos), mole);
        if (after_reset) begin
            if (first_mole < 0) first_mole = mole;
            else check("first_mole_repeat", int'(mole_pos), first_mole);
            after_reset = 1'b0;
        end
        if (kind == K_TIMEOUT || kind == K_NONE || kind == K_STALE) begin
            exp_misses++;
            sb.push_back(make_exp(1'b0, exp_score, exp_misses));
        end
        if (kind != K_STALE) begin
            eval_now   = 1'b0;
            user_guess = 3'd5;
        end
        for (int j = 1; j < ROUND && !answered; j++) begin
            @(negedge clk);
            if (kind == K_RESET && j == ans_j) begin
                do_reset();
                return;
            end
            if ((kind == K_HIT || kind == K_WRONG) && j == ans_j) begin
                if (kind == K_HIT) begin
                    g = mole;
                    exp_score = (exp_score + 1 > SMAX) ? SMAX : exp_score + 1;
                end else begin
                    g = (mole + ((off > 0) ? off : int'($urandom_range(1, 4)))) % 5;
                    exp_misses++;
                end
                eval_now   = 1'b1;
                user_guess = 3'(g);
                sb.push_back(make_exp(kind == K_HIT, exp_score, exp_misses));
                answered = 1'b1;
            end else if (kind == K_NONE) begin
                eval_now   = 1'b1;
                user_guess = 3'($urandom_range(5, 7));
            end else begin
                eval_now   = 1'b0;
                user_guess = 3'd5;
            end
        end
        @(negedge clk);
        eval_now   = 1'b0;
        user_guess = 3'd5;
        #1;
        check("outcome_seen", sb.size(), 0);
        check("window_closed", int'(guess_now), 0);
    endtask

    task automatic random_round();
        int r;
        r = int'($urandom_range(0, 9));
        if (r <= 4)      play_round(K_HIT, int'($urandom_range(1, ROUND - 1)), 0);
        else if (r == 5) play_round(K_WRONG, int'($urandom_range(1, ROUND - 1)), 0);
        else if (r == 6) play_round(K_TIMEOUT, 0, 0);
        else if (r == 7) play_round(K_NONE, 0, 0);
        else if (r == 8) play_round(K_STALE, 0, 0);
        else             play_round(K_HIT, ROUND - 1, 0);
    endtask

    task automatic play_out();
        int rounds;
        rounds = 0;
        while (exp_misses < MAXM && rounds < 60) begin
            random_round();
            rounds++;
        end
        check("game_ended", exp_misses, MAXM);
    endtask

    // Game over holds: no window, frozen counters, inputs ignored.
    task automatic check_over();
        for (int i = 0; i < 6; i++) begin
            check("over_flag", int'(game_over), 1);
            check("over_guess_now", int'(guess_now), 0);
            check("over_mole", int'(mole_pos), 5);
            check("over_score", int'(score), exp_score);
            check("over_misses", int'(misses), exp_misses);
            eval_now   = 1'($urandom);
            user_guess = 3'($urandom_range(0, 7));
            @(negedge clk);
        end
        eval_now   = 1'b0;
        user_guess = 3'd5;
    endtask

    initial begin
        rst        = 1'b1;
        eval_now   = 1'b0;
        user_guess = 3'd5;
        repeat (2) @(negedge clk);

        // Game 0: hit, wrong answer, stale level then timeouts to game over.
        do_reset();
        play_round(K_HIT, 1, 0);
        play_round(K_WRONG, 1, 1);
        play_round(K_STALE, 0, 0);
        play_round(K_STALE, 0, 0);
        check_over();

        // Game 1: score saturation, answer on the timeout cycle, non-answer guesses.
        do_reset();
        play_round(K_HIT, 1, 0);
        play_round(K_HIT, ROUND - 1, 0);
        play_round(K_HIT, 3, 0);
        play_round(K_HIT, 5, 0);
        play_round(K_NONE, 0, 0);
        play_out();
        check_over();

        // Game 2: reset in the middle of a window, then a late wrong answer.
        do_reset();
        play_round(K_HIT, 2, 0);
        play_round(K_RESET, 3, 0);
        play_round(K_WRONG, ROUND - 1, 0);
        play_out();
        check_over();

        for (int g = 0; g < 3; g++) begin
            do_reset();
            play_out();
            check_over();
        end

        repeat (3) @(negedge clk);
        check("sb_drained", sb.size(), 0);
        finish_run();
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

endmodule
